calc_arbiter: RTL and testbench

CALC_ARBITER -- requirements
Module: calc_arbiter

---
 rtl/calc_pkg.sv | 29 ++
 rtl/mux4.sv | 23 ++
 rtl/calc_arbiter.sv | 112 +++++++++++
 tb/tb_calc_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calc arbiter: requester count, FSM encoding and the
// round-robin winner function.
package calc_pkg;

  localparam int unsigned NUM_REQ = 4;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GRANT     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    GRANT     = ST_GRANT,
    WAIT_DONE = ST_WAIT_DONE
  } state_t;

  // Nearest set request after 'last', wrapping; the scan runs far-to-near so the
  // closest index overwrites the result last.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [1:0]         last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux4.sv
// Four-way operand multiplexer.
module mux4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in0;
    unique case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
    endcase
  end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin arbiter granting four requesters access to one shared ALU.
// Define CALC_ARB_TIMEOUT_EN to abort an operation whose alu_done never arrives.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   in3,
  input  logic               alu_done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         sel,
  output logic [WIDTH-1:0]   op_data,
  output logic               alu_start,
  output logic               busy,
  output logic               err
);

  state_t     state;
  logic [1:0] last;
  logic [1:0] pick;

  assign pick = rr_pick(req, last);
  assign busy = (state != IDLE);

`ifdef CALC_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt;
  logic            err_q;
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= 2'd0;
      last      <= 2'd3;
      alu_start <= 1'b0;
`ifdef CALC_ARB_TIMEOUT_EN
      cnt       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      alu_start <= 1'b0;
`ifdef CALC_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            sel       <= pick;
            gnt       <= '0;
            gnt[pick] <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          alu_start <= 1'b1;
          state     <= WAIT_DONE;
`ifdef CALC_ARB_TIMEOUT_EN
          cnt       <= '0;
`endif
        end
        WAIT_DONE: begin
          // alu_done wins over a timeout landing on the same edge
          if (alu_done) begin
            gnt   <= '0;
            last  <= sel;
            state <= IDLE;
          end
`ifdef CALC_ARB_TIMEOUT_EN
          else if (cnt == CntW'(TIMEOUT - 1)) begin
            gnt   <= '0;
            last  <= sel;
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + CntW'(1);
          end
`endif
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  mux4 #(
    .WIDTH(WIDTH)
  ) u_mux4 (
    .sel(sel),
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .out(op_data)
  );

endmodule

// File: tb/tb_calc_arbiter.sv
// Self-checking bench for calc_arbiter: directed scenarios plus randomized operations
// checked against a round-robin reference model.
module tb_calc_arbiter;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] ins [4];
  logic             alu_done;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] op_data;
  logic             alu_start;
  logic             busy;
  logic             err;

  int n_cmp;
  int n_bad;
  int last_m;

  calc_arbiter #(
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .in0      (ins[0]),
    .in1      (ins[1]),
    .in2      (ins[2]),
    .in3      (ins[3]),
    .alu_done (alu_done),
    .gnt      (gnt),
    .sel      (sel),
    .op_data  (op_data),
    .alu_start(alu_start),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Reference: first requester found scanning upward from last+1, wrapping mod 4.
  function automatic int rr_expect(input logic [3:0] r, input int last);
    for (int j = 1; j <= 4; j++) begin
      if (r[(last + j) % 4]) return (last + j) % 4;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = 4'b0000;
    alu_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    last_m = 3;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) ins[i] = 4'(i + 1);
    req = 4'b0000; alu_done = 1'b0;
    #2; rst = 1'b1; #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (sel !== 2'd0) begin n_bad++; $display("FAIL reset_sel: got %0d want 0", sel); end
    n_cmp++; if (busy !== 1'b0 || alu_start !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: got busy=%b start=%b err=%b want 000", busy, alu_start, err);
    end
    n_cmp++; if (op_data !== ins[0]) begin n_bad++; $display("FAIL reset_op: got %h want %h", op_data, ins[0]); end
    @(posedge clk); #1;
    rst = 1'b0; last_m = 3;
    req = 4'b1111;
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL reset_first_arb: got %b want 0001", gnt); end
    req = 4'b0000;
    tick(); tick();
    alu_done = 1'b1; tick(); alu_done = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    tick();  // cycle 1
    n_cmp++; if (gnt !== 4'b0100 || sel !== 2'd2) begin
      n_bad++; $display("FAIL single_grant: got gnt=%b sel=%0d want 0100/2", gnt, sel);
    end
    n_cmp++; if (busy !== 1'b1 || alu_start !== 1'b0) begin
      n_bad++; $display("FAIL single_c1: got busy=%b start=%b want 1/0", busy, alu_start);
    end
    tick();  // cycle 2
    n_cmp++; if (alu_start !== 1'b1) begin n_bad++; $display("FAIL single_start: got %b want 1", alu_start); end
    req = 4'b0000;
    tick();  // cycle 3
    n_cmp++; if (alu_start !== 1'b0 || gnt !== 4'b0100) begin
      n_bad++; $display("FAIL single_c3: got start=%b gnt=%b want 0/0100", alu_start, gnt);
    end
    tick(); tick();  // cycle 5
    alu_done = 1'b1;
    tick();  // cycle 6
    alu_done = 1'b0;
    n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_done: got gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    last_m = 2;
  endtask

  task automatic test_rotation();
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (gnt !== 4'(1 << (k % 4))) begin
        n_bad++; $display("FAIL rotation_%0d: got %b want %b", k, gnt, 4'(1 << (k % 4)));
      end
      tick();
      n_cmp++; if (alu_start !== 1'b1) begin n_bad++; $display("FAIL rotation_start_%0d: got %b want 1", k, alu_start); end
      repeat (3) tick();
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rotation_clear_%0d: got %b want 0000", k, gnt); end
    end
    req = 4'b0000;
    last_m = 0;
  endtask

  task automatic test_routing();
    do_reset();
    ins[0] = 4'h3; ins[1] = 4'hA; ins[2] = 4'hC; ins[3] = 4'h5;
    req = 4'b1010;
    tick();
    n_cmp++; if (gnt !== 4'b0010 || op_data !== 4'hA) begin
      n_bad++; $display("FAIL route_1: got gnt=%b op=%h want 0010/a", gnt, op_data);
    end
    tick();
    alu_done = 1'b1; tick(); alu_done = 1'b0;
    tick();
    n_cmp++; if (gnt !== 4'b1000 || op_data !== 4'h5) begin
      n_bad++; $display("FAIL route_3: got gnt=%b op=%h want 1000/5", gnt, op_data);
    end
    ins[3] = 4'h9; #1;
    n_cmp++; if (op_data !== 4'h9) begin n_bad++; $display("FAIL route_comb: got %h want 9", op_data); end
    req = 4'b0000;
    tick();
    alu_done = 1'b1; tick(); alu_done = 1'b0;
    last_m = 3;
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 4'b0001;
    tick(); tick();
    req = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (gnt !== 4'b0001 || busy !== 1'b1) begin
        n_bad++; $display("FAIL drop_hold_%0d: got gnt=%b busy=%b want 0001/1", i, gnt, busy);
      end
    end
    alu_done = 1'b1; tick(); alu_done = 1'b0;
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL drop_done: got %b want 0000", gnt); end
    alu_done = 1'b1; tick(); alu_done = 1'b0;
    n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0 || alu_start !== 1'b0) begin
      n_bad++; $display("FAIL idle_done_ignored: got gnt=%b busy=%b start=%b want 0000/0/0", gnt, busy, alu_start);
    end
    last_m = 0;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req = 4'b0100;
    tick(); tick(); tick();
    #2; rst = 1'b1; #1;
    n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0) begin
      n_bad++; $display("FAIL rst_mid: got gnt=%b busy=%b sel=%0d want 0000/0/0", gnt, busy, sel);
    end
    n_cmp++; if (err !== 1'b0 || alu_start !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_flags: got err=%b start=%b want 0/0", err, alu_start);
    end
    @(posedge clk); #1;
    rst = 1'b0; last_m = 3;
    req = 4'b0001;
    tick();
    n_cmp++; if (gnt !== 4'b0001 || sel !== 2'd0) begin
      n_bad++; $display("FAIL rst_regrant: got gnt=%b sel=%0d want 0001/0", gnt, sel);
    end
    req = 4'b0000;
    tick();
    alu_done = 1'b1; tick(); alu_done = 1'b0;
    last_m = 0;
  endtask

  task automatic test_random();
    int         e;
    int         d;
    logic [3:0] g_exp;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      req = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) ins[i] = 4'($urandom_range(0, 15));
      e = rr_expect(req, last_m);
      g_exp = 4'(1 << e);
      tick();
      n_cmp++; if (gnt !== g_exp || sel !== 2'(e)) begin
        n_bad++; $display("FAIL rand_grant_%0d: got gnt=%b sel=%0d want %b/%0d", n, gnt, sel, g_exp, e);
      end
      n_cmp++; if (op_data !== ins[e] || busy !== 1'b1) begin
        n_bad++; $display("FAIL rand_op_%0d: got op=%h busy=%b want %h/1", n, op_data, busy, ins[e]);
      end
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      tick();
      n_cmp++; if (alu_start !== 1'b1 || gnt !== g_exp) begin
        n_bad++; $display("FAIL rand_start_%0d: got start=%b gnt=%b want 1/%b", n, alu_start, gnt, g_exp);
      end
      d = $urandom_range(0, 5);
      for (int c = 0; c < d; c++) begin
        tick();
        n_cmp++; if (alu_start !== 1'b0 || gnt !== g_exp || err !== 1'b0) begin
          n_bad++; $display("FAIL rand_wait_%0d: got start=%b gnt=%b err=%b want 0/%b/0", n, alu_start, gnt, err, g_exp);
        end
      end
      alu_done = 1'b1; tick(); alu_done = 1'b0;
      n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
        n_bad++; $display("FAIL rand_done_%0d: got gnt=%b busy=%b want 0000/0", n, gnt, busy);
      end
      last_m = e;
      if ($urandom_range(0, 2) == 0) begin
        req = 4'b0000;
        tick();
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rand_idle_%0d: got %b want 0000", n, gnt); end
      end
    end
    req = 4'b0000;
  endtask

`ifdef CALC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = 4'b0101;
    tick(); tick();  // WAIT_DONE entered on this edge
    for (int c = 1; c < 15; c++) begin
      tick();
      n_cmp++; if (err !== 1'b0 || gnt !== 4'b0001) begin
        n_bad++; $display("FAIL tmo_wait_%0d: got err=%b gnt=%b want 0/0001", c, err, gnt);
      end
    end
    tick();
    n_cmp++; if (err !== 1'b1 || gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL tmo_fire: got err=%b gnt=%b busy=%b want 1/0000/0", err, gnt, busy);
    end
    tick();
    n_cmp++; if (err !== 1'b0 || gnt !== 4'b0100) begin
      n_bad++; $display("FAIL tmo_next: got err=%b gnt=%b want 0/0100", err, gnt);
    end
    req = 4'b0000;
    tick();
    for (int c = 1; c < 15; c++) tick();
    alu_done = 1'b1; tick(); alu_done = 1'b0;
    n_cmp++; if (err !== 1'b0 || gnt !== 4'b0000) begin
      n_bad++; $display("FAIL tmo_tie: got err=%b gnt=%b want 0/0000", err, gnt);
    end
    tick();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tmo_tie_late: got %b want 0", err); end
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    req = 4'b0010;
    tick(); tick();
    req = 4'b0000;
    for (int c = 0; c < 40; c++) begin
      tick();
      n_cmp++; if (err !== 1'b0 || gnt !== 4'b0010) begin
        n_bad++; $display("FAIL notmo_%0d: got err=%b gnt=%b want 0/0010", c, err, gnt);
      end
    end
    alu_done = 1'b1; tick(); alu_done = 1'b0;
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL notmo_done: got %b want 0000", gnt); end
  endtask
`endif

  initial begin
    n_cmp = 0; n_bad = 0; last_m = 3;
    rst = 1'b0; req = 4'b0000; alu_done = 1'b0;
    for (int i = 0; i < 4; i++) ins[i] = '0;
    test_reset();
    test_single();
    test_rotation();
    test_routing();
    test_req_drop();
    test_reset_mid_op();
    test_random();
`ifdef CALC_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
